// File: rtl/mem_dma_ctrl.sv
// mem_dma_ctrl: splits one cache-block read fill or write-back into memory-bus beats
module mem_dma_ctrl #(
  parameter int block_width_p = 8,
  parameter int dma_data_width_p = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_we_i,
  input  logic [31:0]                   req_addr_i,
  input  logic [block_width_p*32-1:0]   req_wdata_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic                          resp_we_o,
  output logic [block_width_p*32-1:0]   resp_rdata_o,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic                          mem_we_o,
  output logic [31:0]                   mem_addr_o,
  output logic [dma_data_width_p*32-1:0] mem_wdata_o,
  input  logic                          mem_valid_i,
  input  logic [dma_data_width_p*32-1:0] mem_data_i
);
  localparam int beats_lp = block_width_p / dma_data_width_p;
  localparam int cw_lp = beats_lp > 1 ? $clog2(beats_lp) : 1;
  localparam int bw_lp = dma_data_width_p * 32;
  localparam logic [31:0] mask_lp = ~((32'd1 << ($clog2(block_width_p) + 2)) - 32'd1);
  localparam logic [31:0] step_lp = 32'(dma_data_width_p * 4);
  localparam logic [cw_lp-1:0] last_lp = cw_lp'(beats_lp - 1);

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_DATA, RESP} state_t;

  state_t                     r_state;
  logic [cw_lp-1:0]           r_beat;
  logic [31:0]                r_base;
  logic                       r_we;
  logic [block_width_p*32-1:0] r_wdata;
  logic [block_width_p*32-1:0] r_rdata;
  logic                       r_req_ready;
  logic                       r_mem_valid;
  logic                       r_mem_we;
  logic                       r_resp_valid;
  logic                       w_last;

  assign w_last = r_beat == last_lp;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_base       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_req_ready  <= 1'b1;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid_i) begin
          r_base      <= req_addr_i & mask_lp;
          r_we        <= req_we_i;
          r_wdata     <= req_wdata_i;
          r_beat      <= '0;
          r_req_ready <= 1'b0;
          r_mem_valid <= 1'b1;
          r_mem_we    <= req_we_i;
          r_state     <= req_we_i ? WRITE : RD_REQ;
        end
        WRITE: if (mem_ready_i) begin
          r_beat <= w_last ? '0 : r_beat + cw_lp'(1);
          if (w_last) begin
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RD_REQ: if (mem_ready_i) begin
          r_mem_valid <= 1'b0;
          r_state     <= RD_DATA;
        end
        RD_DATA: if (mem_valid_i) begin
          r_rdata[int'(r_beat)*bw_lp +: bw_lp] <= mem_data_i;
          r_beat <= w_last ? '0 : r_beat + cw_lp'(1);
          if (w_last) begin
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: if (resp_ready_i) begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = r_req_ready;
  assign resp_valid_o = r_resp_valid;
  assign resp_we_o    = r_resp_valid & r_we;
  assign resp_rdata_o = r_rdata;
  assign mem_valid_o  = r_mem_valid;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_valid ? r_base + 32'(r_beat) * step_lp : '0;
  assign mem_wdata_o  = r_mem_we ? r_wdata[int'(r_beat)*bw_lp +: bw_lp] : '0;
endmodule

// File: tb/tb_mem_dma_ctrl.sv
// tb_mem_dma_ctrl: vector table, corner sequences and randomized traffic against a memory scoreboard
module tb_mem_dma_ctrl;
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic         req_valid_i, req_ready_o, req_we_i;
  logic [31:0]  req_addr_i;
  logic [255:0] req_wdata_i;
  logic         resp_valid_o, resp_ready_i, resp_we_o;
  logic [255:0] resp_rdata_o;
  logic         mem_valid_o, mem_ready_i, mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [63:0]  mem_wdata_o;
  logic         mem_valid_i;
  logic [63:0]  mem_data_i;

  mem_dma_ctrl u0 (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_we_o(resp_we_o),
    .resp_rdata_o(resp_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i)
  );

  logic         u_req_valid, u_req_ready, u_req_we;
  logic [31:0]  u_req_addr;
  logic [255:0] u_req_wdata;
  logic         u_resp_valid, u_resp_ready, u_resp_we;
  logic [255:0] u_resp_rdata;
  logic         u_mem_valid_o, u_mem_ready, u_mem_we;
  logic [31:0]  u_mem_addr;
  logic [255:0] u_mem_wdata;
  logic         u_mem_valid_i;
  logic [255:0] u_mem_data;

  mem_dma_ctrl #(.block_width_p(8), .dma_data_width_p(8)) u1 (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(u_req_valid), .req_ready_o(u_req_ready), .req_we_i(u_req_we),
    .req_addr_i(u_req_addr), .req_wdata_i(u_req_wdata),
    .resp_valid_o(u_resp_valid), .resp_ready_i(u_resp_ready), .resp_we_o(u_resp_we),
    .resp_rdata_o(u_resp_rdata),
    .mem_valid_o(u_mem_valid_o), .mem_ready_i(u_mem_ready), .mem_we_o(u_mem_we),
    .mem_addr_o(u_mem_addr), .mem_wdata_o(u_mem_wdata),
    .mem_valid_i(u_mem_valid_i), .mem_data_i(u_mem_data)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // main memory as seen on the bus, and the block contents the cache believes it wrote
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] shadow  [logic [31:0]];

  function automatic logic [31:0] init_w(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction
  function automatic logic [31:0] get_bus(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_w(a);
  endfunction
  function automatic logic [31:0] get_sh(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_w(a);
  endfunction
  function automatic logic [255:0] mkblk(input logic [31:0] s, input logic [31:0] st);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = s + st * 32'(i);
    return b;
  endfunction

  int stall_pct = 0, gap_pct = 0, stray_pct = 0, rdly = 0;
  int wb, nreq, nmv;
  logic [31:0]  cur_base;
  logic [255:0] cur_wdata;
  logic [255:0] last_rd;
  logic [63:0]  rd_q[$];

  // one negedge of the memory: decide ready, record write beats, stream read beats
  task automatic mem_cycle();
    logic [31:0] ea;
    mem_ready_i = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
    mem_valid_i = 1'b0;
    mem_data_i  = {$urandom, $urandom};
    if (mem_valid_o) nmv++;
    if (mem_valid_o && mem_ready_i) begin
      if (mem_we_o) begin
        ea = cur_base + 32'(wb * 8);
        chk("wr_addr", mem_addr_o, ea);
        chk("wr_data", mem_wdata_o, cur_wdata[(wb & 3)*64 +: 64]);
        bus_mem[mem_addr_o]         = mem_wdata_o[31:0];
        bus_mem[mem_addr_o + 32'd4] = mem_wdata_o[63:32];
        wb++;
      end else begin
        chk("rd_addr", mem_addr_o, cur_base);
        for (int k = 0; k < 4; k++)
          rd_q.push_back({get_bus(mem_addr_o + 32'(8*k + 4)), get_bus(mem_addr_o + 32'(8*k))});
        nreq++;
      end
    end else if (rd_q.size() > 0) begin
      if ($urandom_range(0, 99) >= gap_pct) begin
        mem_valid_i = 1'b1;
        mem_data_i  = rd_q.pop_front();
      end
    end else begin
      mem_valid_i = ($urandom_range(0, 99) < stray_pct);
    end
  endtask

  task automatic run_until_resp(output logic [255:0] rd, output logic rwe);
    int c = 0;
    while (c < 300 && !resp_valid_o) begin
      mem_cycle();
      @(negedge clk);
      c++;
    end
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b0;
    chk("resp_seen", resp_valid_o, 1);
    rd  = resp_rdata_o;
    rwe = resp_we_o;
    repeat (rdly) begin
      @(negedge clk);
      chk("resp_hold", {req_ready_o, resp_valid_o, resp_rdata_o}, {2'b01, rd});
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    chk("resp_done", {resp_valid_o, req_ready_o}, 2'b01);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [255:0] wd,
                      input logic [31:0] base, output logic [255:0] rd);
    logic rwe;
    logic [255:0] eb;
    cur_base = base; cur_wdata = wd; wb = 0; nreq = 0; nmv = 0;
    rd_q.delete();
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("busy", req_ready_o, 0);
    if (we) for (int i = 0; i < 8; i++) shadow[base + 32'(4*i)] = wd[32*i +: 32];
    run_until_resp(rd, rwe);
    chk("resp_we", rwe, we);
    chk("beats", wb, we ? 4 : 0);
    chk("rd_reqs", nreq, we ? 0 : 1);
    if (we) chk("wr_rdata_hold", rd, last_rd);
    else begin
      for (int i = 0; i < 8; i++) eb[32*i +: 32] = get_sh(base + 32'(4*i));
      chk("rd_block", rd, eb);
      last_rd = rd;
    end
  endtask

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  base;
    logic [255:0] wd;
    logic [255:0] exp_rd;
  } vec_t;
  vec_t tbl[6];

  logic [31:0]  sa[7];
  logic [63:0]  sd[7];
  logic [31:0]  log_a[$];
  logic [63:0]  log_d[$];
  logic [255:0] rd, pat;
  logic [31:0]  ra;
  logic [255:0] rw;
  logic         rwe;
  int           stalls;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0104, 32'h0000_0100, mkblk(32'h11, 32'h11), '0};
    tbl[1] = '{1'b1, 32'h0000_0200, 32'h0000_0200, mkblk(32'h0, 32'h1), '0};
    tbl[2] = '{1'b0, 32'h0000_021C, 32'h0000_0200, '0, mkblk(32'h0, 32'h1)};
    tbl[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, mkblk(32'hA0, 32'h1), '0};
    tbl[4] = '{1'b0, 32'hFFFF_FFE4, 32'hFFFF_FFE0, '0, mkblk(32'hA0, 32'h1)};
    tbl[5] = '{1'b0, 32'h0000_0100, 32'h0000_0100, '0, mkblk(32'h11, 32'h11)};
    sa = '{32'h100, 32'h108, 32'h110, 32'h110, 32'h110, 32'h110, 32'h118};
    sd = '{64'h22_0000_0011, 64'h44_0000_0033, 64'h66_0000_0055, 64'h66_0000_0055,
           64'h66_0000_0055, 64'h66_0000_0055, 64'h88_0000_0077};

    reset_i = 1'b1;
    req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0; resp_ready_i = 0;
    mem_ready_i = 0; mem_valid_i = 0; mem_data_i = 0;
    u_req_valid = 0; u_req_we = 0; u_req_addr = 0; u_req_wdata = 0; u_resp_ready = 0;
    u_mem_ready = 0; u_mem_valid_i = 0; u_mem_data = 0;
    last_rd = '0;
    #2;
    chk("reset_ctl", {req_ready_o, resp_valid_o, resp_we_o, mem_valid_o, mem_we_o}, 5'b10000);
    chk("reset_data", {mem_addr_o, mem_wdata_o, resp_rdata_o}, '0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", req_ready_o, 1);

    for (int t = 0; t < 6; t++) begin
      xact(tbl[t].we, tbl[t].addr, tbl[t].wd, tbl[t].base, rd);
      chk("tbl_mv_cycles", nmv, tbl[t].we ? 4 : 1);
      if (!tbl[t].we) chk("tbl_rdata", rd, tbl[t].exp_rd);
    end

    // write with three stalled cycles on beat 2
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h104; req_wdata_i = mkblk(32'h11, 32'h11);
    @(negedge clk);
    req_valid_i = 1'b0;
    stalls = 0;
    for (int c = 0; c < 20 && !resp_valid_o; c++) begin
      if (mem_valid_o) begin log_a.push_back(mem_addr_o); log_d.push_back(mem_wdata_o); end
      mem_ready_i = !(mem_valid_o && mem_addr_o == 32'h110 && stalls < 3);
      if (!mem_ready_i) stalls++;
      @(negedge clk);
    end
    mem_ready_i = 1'b0;
    chk("stall_len", log_a.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk("stall_addr", log_a[i], sa[i]);
      chk("stall_data", log_d[i], sd[i]);
    end

    // response back-pressure with a pending request
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h108;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", {resp_valid_o, resp_we_o, req_ready_o, mem_valid_o, resp_rdata_o},
          {4'b1100, last_rd});
      @(negedge clk);
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    chk("bp_no_same_cycle", {resp_valid_o, req_ready_o, mem_valid_o}, 3'b010);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("bp_accept", {mem_valid_o, mem_we_o, req_ready_o, mem_addr_o}, {3'b100, 32'h100});
    cur_base = 32'h100; wb = 0; nreq = 0; rd_q.delete();
    run_until_resp(rd, rwe);
    chk("bp_rdata", rd, mkblk(32'h11, 32'h11));
    chk("bp_rdreq", nreq, 1);
    last_rd = rd;

    // reset in the middle of a read, then stray beats
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h204;
    @(negedge clk);
    req_valid_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk);
    mem_ready_i = 1'b0; mem_valid_i = 1'b1; mem_data_i = 64'h1_0000_0000;
    @(negedge clk);
    mem_data_i = 64'h3_0000_0002;
    @(negedge clk);
    mem_valid_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    chk("async_rst_ctl", {req_ready_o, resp_valid_o, resp_we_o, mem_valid_o, mem_we_o}, 5'b10000);
    chk("async_rst_data", {mem_addr_o, resp_rdata_o}, '0);
    @(negedge clk);
    reset_i = 1'b0;
    mem_valid_i = 1'b1; mem_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    mem_valid_i = 1'b0;
    chk("stray_ignored", {req_ready_o, mem_valid_o, resp_valid_o, resp_rdata_o}, {3'b100, 256'h0});
    last_rd = '0;
    xact(1'b0, 32'h300, '0, 32'h300, rd);
    chk("after_rst_w0", rd[31:0], init_w(32'h300));

    // single-beat configuration: latency and write
    pat = mkblk(32'h5000, 32'h3);
    u_req_valid = 1'b1; u_req_we = 1'b0; u_req_addr = 32'h41C;
    @(negedge clk);
    u_req_valid = 1'b0;
    chk("sb_cyc1", {u_mem_valid_o, u_mem_we, u_resp_valid, u_mem_addr}, {3'b100, 32'h400});
    u_mem_ready = 1'b1;
    @(negedge clk);
    u_mem_ready = 1'b0;
    chk("sb_cyc2", {u_mem_valid_o, u_resp_valid}, 2'b00);
    u_mem_valid_i = 1'b1; u_mem_data = pat;
    @(negedge clk);
    u_mem_valid_i = 1'b0;
    chk("sb_cyc3", {u_resp_valid, u_resp_we, u_resp_rdata}, {2'b10, pat});
    u_resp_ready = 1'b1;
    @(negedge clk);
    u_resp_ready = 1'b0;
    chk("sb_done", {u_resp_valid, u_req_ready}, 2'b01);
    u_req_valid = 1'b1; u_req_we = 1'b1; u_req_addr = 32'h800; u_req_wdata = mkblk(32'h9, 32'h9);
    @(negedge clk);
    u_req_valid = 1'b0;
    chk("sb_wr_beat", {u_mem_valid_o, u_mem_we, u_mem_addr, u_mem_wdata},
        {2'b11, 32'h800, mkblk(32'h9, 32'h9)});
    u_mem_ready = 1'b1;
    @(negedge clk);
    u_mem_ready = 1'b0;
    chk("sb_wr_resp", {u_mem_valid_o, u_resp_valid, u_resp_we, u_resp_rdata}, {3'b011, pat});
    u_resp_ready = 1'b1;
    @(negedge clk);
    u_resp_ready = 1'b0;

    // randomized traffic over a few blocks, checked by write-then-read consistency
    stall_pct = 30; gap_pct = 40; stray_pct = 20;
    for (int t = 0; t < 40; t++) begin
      ra = 32'h1000 + 32'($urandom_range(0, 5)) * 32'd32 + 32'($urandom_range(0, 31));
      for (int i = 0; i < 8; i++) rw[32*i +: 32] = $urandom;
      rdly = $urandom_range(0, 2);
      xact(1'($urandom_range(0, 1)), ra, rw, ra & 32'hFFFF_FFE0, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
